ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_rr_pick.sv | 22 ++
 rtl/ram_arbiter.sv | 136 +++++++++++++
 tb/tb_ram_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester single-port RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2
    } state_e;

    typedef logic [0:0] req_id_t;

    // With two requesters the "other" requester is simply the inverted id.
    function automatic req_id_t other_id(input req_id_t id);
        return req_id_t'(~id);
    endfunction

endpackage

// File: rtl/ram_rr_pick.sv
// Round-robin winner selection between the two requesters.
module ram_rr_pick
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               last_i,
    output logic               winner_o,
    output logic               valid_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = 1'b0;
        case (req_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = 1'(other_id(req_id_t'(last_i)));
            default: winner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one single-port RAM; one transaction at a time.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [DATA_W-1:0]         ram_data_in,
    output logic                      ram_write_enb,
    output logic                      ram_read_enb,
    output logic [ADDR_W-1:0]         ram_address,
    input  logic [DATA_W-1:0]         ram_data_out
);

    state_e              state_q, state_d;
    req_id_t             last_q, last_d;
    req_id_t             id_q, id_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
    logic                busy_q, busy_d;
    logic                wen_q, wen_d;
    logic                ren_q, ren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [DATA_W-1:0]   rhold_q, rhold_d;

    logic                pick_winner;
    logic                pick_valid;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    ram_rr_pick u_pick (
        .req_i    (req),
        .last_i   (1'(last_q)),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    assign sel_we    = we[pick_winner];
    assign sel_addr  = pick_winner ? addr[2*ADDR_W-1 -: ADDR_W]  : addr[ADDR_W-1:0];
    assign sel_wdata = pick_winner ? wdata[2*DATA_W-1 -: DATA_W] : wdata[DATA_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= req_id_t'(1'b1);
            id_q     <= req_id_t'(1'b0);
            gnt_q    <= '0;
            rvalid_q <= '0;
            busy_q   <= 1'b0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            rhold_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
            wen_q    <= wen_d;
            ren_q    <= ren_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rhold_q  <= rhold_d;
        end
    end

    // Outputs are computed for the state being entered so they appear registered in it.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        gnt_d    = '0;
        rvalid_d = '0;
        wen_d    = 1'b0;
        ren_d    = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        rhold_d  = rhold_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d             = ACCESS;
                    id_d                = req_id_t'(pick_winner);
                    last_d              = req_id_t'(pick_winner);
                    gnt_d[pick_winner]  = 1'b1;
                    addr_d              = sel_addr;
                    din_d               = sel_wdata;
                    wen_d               = sel_we;
                    ren_d               = ~sel_we;
                end
            end
            ACCESS: begin
                if (wen_q) begin
                    state_d = IDLE;
                end else begin
                    state_d        = RD_WAIT;
                    rvalid_d[id_q] = 1'b1;
                end
            end
            RD_WAIT: begin
                state_d = IDLE;
                rhold_d = ram_data_out;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign gnt           = gnt_q;
    assign rvalid        = rvalid_q;
    assign busy          = busy_q;
    assign ram_write_enb = wen_q;
    assign ram_read_enb  = ren_q;
    assign ram_address   = addr_q;
    assign ram_data_in   = din_q;
    // Read data passes straight through in the valid cycle, then is held.
    assign rdata         = rvalid_q ? ram_data_out : rhold_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, transaction-schedule reference model, directed and random traffic.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [11:0] addr = 12'h000;
    logic [15:0] wdata = 16'h0000;
    logic [1:0]  gnt, rvalid;
    logic [7:0]  rdata, ram_data_in, ram_data_out;
    logic        busy, ram_write_enb, ram_read_enb;
    logic [5:0]  ram_address;

    ram_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .gnt           (gnt),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .busy          (busy),
        .ram_data_in   (ram_data_in),
        .ram_write_enb (ram_write_enb),
        .ram_read_enb  (ram_read_enb),
        .ram_address   (ram_address),
        .ram_data_out  (ram_data_out)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle registered read.
    logic [7:0] ram_mem [64] = '{default: 8'h00};
    logic [7:0] ram_q = 8'h00;
    always @(posedge clk) begin
        if (ram_write_enb) ram_mem[ram_address] <= ram_data_in;
        if (ram_read_enb)  ram_q <= ram_mem[ram_address];
    end
    assign ram_data_out = ram_q;

    int total = 0;
    int bad = 0;
    int k = 0;
    int free_c = 0;
    logic       last_m;
    logic [7:0] mem_m [64] = '{default: 8'h00};
    logic [7:0] rdata_exp;

    // Expected outputs per cycle, indexed by edge count modulo 4.
    logic [1:0] e_gnt [4];
    logic [1:0] e_rv [4];
    logic       e_busy [4];
    logic       e_wen [4];
    logic       e_ren [4];
    logic       e_rset [4];
    logic [5:0] e_addr [4];
    logic [7:0] e_din [4];
    logic [7:0] e_rd [4];

    logic [1:0] seq33 [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_slot(input int s);
        e_gnt[s] = 2'b00; e_rv[s] = 2'b00; e_busy[s] = 1'b0; e_wen[s] = 1'b0;
        e_ren[s] = 1'b0; e_rset[s] = 1'b0; e_addr[s] = 6'h00; e_din[s] = 8'h00; e_rd[s] = 8'h00;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) clear_slot(i);
        last_m    = 1'b1;
        free_c    = k;
        rdata_exp = 8'h00;
    endtask

    // Advance one clock: model the edge, then compare all outputs just after it.
    task automatic cycle();
        int s, s1;
        logic w;
        logic [5:0] a;
        logic [7:0] d;
        @(posedge clk);
        k++;
        s  = k & 3;
        s1 = (k + 1) & 3;
        if (!reset && (k - 1) >= free_c && req != 2'b00) begin
            w      = (req == 2'b11) ? ~last_m : req[1];
            last_m = w;
            a      = w ? addr[11:6] : addr[5:0];
            d      = w ? wdata[15:8] : wdata[7:0];
            e_gnt[s]  = 2'b01 << w;
            e_busy[s] = 1'b1;
            e_addr[s] = a;
            if (we[w]) begin
                e_wen[s] = 1'b1;
                e_din[s] = d;
                mem_m[a] = d;
                free_c   = k + 1;
            end else begin
                e_ren[s]   = 1'b1;
                e_rv[s1]   = 2'b01 << w;
                e_busy[s1] = 1'b1;
                e_rset[s1] = 1'b1;
                e_rd[s1]   = mem_m[a];
                free_c     = k + 2;
            end
        end
        #1;
        if (reset) begin
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_rvalid", 32'(rvalid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_en", 32'({ram_write_enb, ram_read_enb}), 0);
            chk("rst_rdata", 32'(rdata), 0);
            chk("rst_addr", 32'(ram_address), 0);
            chk("rst_din", 32'(ram_data_in), 0);
        end else begin
            if (e_rset[s]) rdata_exp = e_rd[s];
            chk("gnt", 32'(gnt), 32'(e_gnt[s]));
            chk("rvalid", 32'(rvalid), 32'(e_rv[s]));
            chk("busy", 32'(busy), 32'(e_busy[s]));
            chk("wen", 32'(ram_write_enb), 32'(e_wen[s]));
            chk("ren", 32'(ram_read_enb), 32'(e_ren[s]));
            chk("rdata", 32'(rdata), 32'(rdata_exp));
            if (e_wen[s] || e_ren[s]) chk("ram_addr", 32'(ram_address), 32'(e_addr[s]));
            if (e_wen[s]) chk("ram_din", 32'(ram_data_in), 32'(e_din[s]));
        end
        chk("inv_en_excl", 32'(ram_write_enb & ram_read_enb), 0);
        chk("inv_onehot", 32'($onehot0({gnt, rvalid})), 1);
        clear_slot(s);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    function automatic logic [5:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 6'h00;
            1:       return 6'h3F;
            2:       return 6'($urandom_range(0, 7));
            default: return 6'($urandom);
        endcase
    endfunction

    logic [1:0] pend = 2'b00;
    logic [1:0] gnt_prev = 2'b00;
    int         wait_c [2] = '{0, 0};

    initial begin
        model_reset();
        repeat (2) cycle();
        chk("reset_gnt_lit", 32'(gnt), 0);
        chk("reset_busy_lit", 32'(busy), 0);
        reset = 1'b0;

        // Write 0xA5 to 0x3F from requester 0.
        req = 2'b01; we = 2'b01; addr = {6'h00, 6'h3F}; wdata = {8'h00, 8'hA5};
        cycle();
        chk("w31_gnt", 32'(gnt), 32'h1);
        chk("w31_wen", 32'(ram_write_enb), 1);
        chk("w31_addr", 32'(ram_address), 32'h3F);
        chk("w31_din", 32'(ram_data_in), 32'hA5);
        chk("w31_busy", 32'(busy), 1);
        cycle();
        req = 2'b00;
        chk("w31_idle", 32'(busy), 0);

        // Read 0x3F back from requester 1.
        req = 2'b10; we = 2'b00; addr = {6'h3F, 6'h00};
        cycle();
        chk("r32_gnt", 32'(gnt), 32'h2);
        chk("r32_ren", 32'(ram_read_enb), 1);
        cycle();
        req = 2'b00;
        chk("r32_rvalid", 32'(rvalid), 32'h2);
        chk("r32_rdata", 32'(rdata), 32'hA5);
        cycle();
        chk("r32_hold", 32'(rdata), 32'hA5);

        // Request dropped during ACCESS still executes.
        req = 2'b01; we = 2'b01; addr = {6'h00, 6'h2A}; wdata = {8'h00, 8'h5C};
        cycle();
        req = 2'b00;
        chk("w22_gnt", 32'(gnt), 32'h1);
        repeat (2) cycle();
        req = 2'b10; we = 2'b00; addr = {6'h2A, 6'h00};
        repeat (2) cycle();
        req = 2'b00;
        chk("r22_rdata", 32'(rdata), 32'h5C);
        cycle();

        // Both requesting from reset: grants alternate.
        req = 2'b11; we = 2'b11; addr = {6'h20, 6'h10}; wdata = {8'h22, 8'h11};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk($sformatf("rr33_gnt%0d", i), 32'(gnt), 32'(seq33[i]));
        end
        req = 2'b00;
        repeat (2) cycle();

        // Simultaneous write by 0 and read by 1 of address 0.
        req = 2'b11; we = 2'b01; addr = 12'h000; wdata = {8'h00, 8'h11};
        do_reset();
        cycle();
        chk("c34_gnt0", 32'(gnt), 32'h1);
        req = 2'b10;
        cycle();
        chk("c34_idle", 32'(gnt), 0);
        cycle();
        chk("c34_gnt1", 32'(gnt), 32'h2);
        cycle();
        req = 2'b00;
        chk("c34_rvalid", 32'(rvalid), 32'h2);
        chk("c34_rdata", 32'(rdata), 32'h11);

        // Reset in RD_WAIT aborts; requester 0 wins the next tie.
        req = 2'b10; we = 2'b00; addr = {6'h3F, 6'h00};
        do_reset();
        cycle();
        cycle();
        chk("a35_rdwait", 32'(rvalid), 32'h2);
        req = 2'b11; we = 2'b11; wdata = 16'h7733;
        reset = 1'b1;
        model_reset();
        #1;
        chk("a35_rvalid", 32'(rvalid), 0);
        chk("a35_busy", 32'(busy), 0);
        chk("a35_rdata", 32'(rdata), 0);
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        chk("a35_first", 32'(gnt), 32'h1);
        req = 2'b00;
        repeat (2) cycle();

        // Random traffic from both requesters.
        for (int it = 0; it < 3000; it++) begin
            cycle();
            for (int n = 0; n < 2; n++) begin
                if (gnt_prev[n]) begin
                    pend[n] = 1'b0;
                    chk("wait_bound", 32'(wait_c[n] <= 6), 1);
                    wait_c[n] = 0;
                end else if (pend[n]) begin
                    wait_c[n]++;
                end
                if (!pend[n] && $urandom_range(0, 2) == 0) begin
                    pend[n]            = 1'b1;
                    we[n]              = 1'($urandom_range(0, 1));
                    addr[n*6 +: 6]     = rand_addr();
                    wdata[n*8 +: 8]    = 8'($urandom);
                end
            end
            gnt_prev = gnt;
            req      = pend;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
